// File: rtl/vx_alu_commit_assembler.sv
// rtl/vx_alu_commit_assembler.sv - reassembles partial-warp ALU commits into one full-warp commit
// Holds one warp; flags sequencing errors (sticky) and counts handed-off warps.
module vx_alu_commit_assembler #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 2,
    parameter int XLEN        = 32,
    parameter int NW_WIDTH    = 2,
    parameter int UUID_WIDTH  = 1,
    parameter int PC_BITS     = 30,
    parameter int NR_BITS     = 6,
    parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [NW_WIDTH-1:0]         in_wid,
    input  logic [PC_BITS-1:0]          in_pc,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic                        in_wb,
    input  logic [NUM_LANES-1:0]        in_tmask,
    input  logic [NUM_LANES*XLEN-1:0]   in_data,
    input  logic [PID_WIDTH-1:0]        in_pid,
    input  logic                        in_sop,
    input  logic                        in_eop,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [NW_WIDTH-1:0]         out_wid,
    output logic [PC_BITS-1:0]          out_pc,
    output logic [NR_BITS-1:0]          out_rd,
    output logic                        out_wb,
    output logic [NUM_THREADS-1:0]      out_tmask,
    output logic [NUM_THREADS*XLEN-1:0] out_data,
    output logic                        err,
    output logic [31:0]                 commit_count
);
    localparam int NUM_PKTS = NUM_THREADS / NUM_LANES;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FULL} state_t;

    state_t                      r_state;
    logic                        r_out_valid;
    logic [UUID_WIDTH-1:0]       r_uuid;
    logic [NW_WIDTH-1:0]         r_wid;
    logic [PC_BITS-1:0]          r_pc;
    logic [NR_BITS-1:0]          r_rd;
    logic                        r_wb;
    logic [NUM_THREADS-1:0]      r_tmask;
    logic [NUM_THREADS*XLEN-1:0] r_data;
    logic [NUM_PKTS-1:0]         r_seen;
    logic                        r_err;
    logic [31:0]                 r_count;

    logic                        w_fire;
    logic                        w_deq;
    logic [PID_WIDTH-1:0]        w_pidx;
    logic                        w_eop;
    logic                        w_match;
    logic                        w_start;
    logic                        w_cont;
    logic                        w_place;
    logic                        w_dup;
    logic                        w_err_set;
    logic [NUM_THREADS-1:0]      w_tmask_n;
    logic [NUM_THREADS*XLEN-1:0] w_data_n;
    logic [NUM_PKTS-1:0]         w_seen_n;

    assign in_ready = (r_state != S_FULL) || out_ready;
    assign w_fire   = in_valid && in_ready;
    assign w_deq    = r_out_valid && out_ready;

    // Full-width packets carry the whole warp: pid is meaningless and eop is implied.
    assign w_pidx   = (NUM_PKTS == 1) ? '0 : in_pid;
    assign w_eop    = (NUM_PKTS == 1) ? 1'b1 : in_eop;
    assign w_match  = (in_wid == r_wid) && (in_uuid == r_uuid);

    // A sop always (re)starts a warp; a FULL slot that accepts input is draining, so acts as IDLE.
    assign w_start  = w_fire && in_sop;
    assign w_cont   = w_fire && !in_sop && (r_state == S_ACCUM) && w_match;
    assign w_place  = w_start || w_cont;
    assign w_dup    = w_cont && r_seen[w_pidx];

    assign w_err_set = (w_fire && !in_sop && (r_state != S_ACCUM))
                     || (w_fire && in_sop && (r_state == S_ACCUM))
                     || (w_fire && !in_sop && (r_state == S_ACCUM) && !w_match)
                     || w_dup
                     || ((NUM_PKTS == 1) && w_fire && !in_eop);

    always_comb begin
        w_tmask_n = w_start ? '0 : r_tmask;
        w_data_n  = w_start ? '0 : r_data;
        w_seen_n  = (w_start ? '0 : r_seen) | (NUM_PKTS'(1) << w_pidx);
        for (int p = 0; p < NUM_PKTS; p++) begin
            if (PID_WIDTH'(p) == w_pidx) begin
                w_tmask_n[p*NUM_LANES +: NUM_LANES]      = in_tmask;
                w_data_n[p*NUM_LANES*XLEN +: NUM_LANES*XLEN] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_uuid      <= '0;
            r_wid       <= '0;
            r_pc        <= '0;
            r_rd        <= '0;
            r_wb        <= 1'b0;
            r_tmask     <= '0;
            r_data      <= '0;
            r_seen      <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_deq) begin
                r_count     <= r_count + 32'd1;
                r_out_valid <= 1'b0;
                r_state     <= S_IDLE;
            end
            if (w_start) begin
                r_uuid <= in_uuid;
                r_wid  <= in_wid;
                r_pc   <= in_pc;
                r_rd   <= in_rd;
                r_wb   <= in_wb;
            end
            if (w_place) begin
                r_tmask <= w_tmask_n;
                r_data  <= w_data_n;
                r_seen  <= w_seen_n;
                if (w_eop) begin
                    r_state     <= S_FULL;
                    r_out_valid <= 1'b1;
                end else if (w_start) begin
                    r_state <= S_ACCUM;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_uuid     = r_uuid;
    assign out_wid      = r_wid;
    assign out_pc       = r_pc;
    assign out_rd       = r_rd;
    assign out_wb       = r_wb;
    assign out_tmask    = r_tmask;
    assign out_data     = r_data;
    assign err          = r_err;
    assign commit_count = r_count;
endmodule

// File: tb/tb_vx_alu_commit_assembler.sv
// tb/tb_vx_alu_commit_assembler.sv - directed self-checking bench for vx_alu_commit_assembler
module tb_vx_alu_commit_assembler;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [0:0]   in_uuid;
    logic [1:0]   in_wid;
    logic [29:0]  in_pc;
    logic [5:0]   in_rd;
    logic         in_wb;
    logic [1:0]   in_tmask;
    logic [63:0]  in_data;
    logic [0:0]   in_pid;
    logic         in_sop;
    logic         in_eop;
    logic         out_valid;
    logic         out_ready;
    logic [0:0]   out_uuid;
    logic [1:0]   out_wid;
    logic [29:0]  out_pc;
    logic [5:0]   out_rd;
    logic         out_wb;
    logic [3:0]   out_tmask;
    logic [127:0] out_data;
    logic         err;
    logic [31:0]  commit_count;

    int n_cmp = 0;
    int n_bad = 0;

    vx_alu_commit_assembler dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_uuid(in_uuid), .in_wid(in_wid), .in_pc(in_pc), .in_rd(in_rd), .in_wb(in_wb),
        .in_tmask(in_tmask), .in_data(in_data), .in_pid(in_pid), .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_uuid(out_uuid), .out_wid(out_wid), .out_pc(out_pc), .out_rd(out_rd), .out_wb(out_wb),
        .out_tmask(out_tmask), .out_data(out_data),
        .err(err), .commit_count(commit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input logic pid, input logic sop, input logic eop, input logic [1:0] wid,
                           input logic uuid, input logic [1:0] tm, input logic [31:0] d0, input logic [31:0] d1);
        in_valid = 1'b1;
        in_pid   = pid;
        in_sop   = sop;
        in_eop   = eop;
        in_wid   = wid;
        in_uuid  = uuid;
        in_tmask = tm;
        in_data  = {d1, d0};
        in_pc    = 30'h100;
        in_rd    = 6'd5;
        in_wb    = 1'b1;
    endtask

    function automatic logic [127:0] pack4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        return {d, c, b, a};
    endfunction

    task automatic pulse_reset();
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        reset    = 1'b1;
    endtask

    initial begin
        logic [31:0] base;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pid = '0; in_sop = 1'b0; in_eop = 1'b0; in_wid = '0; in_uuid = '0;
        in_tmask = '0; in_data = '0; in_pc = '0; in_rd = '0; in_wb = 1'b0;
        tick(); tick();
        reset = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_count", commit_count, 0);
        chk("rst_tmask", out_tmask, 0);
        chk("rst_in_ready", in_ready, 1);

        // two-packet warp
        set_pkt(0, 1, 0, 1, 0, 2'b11, 32'hA, 32'hB); tick();
        chk("t1_accum_valid", out_valid, 0);
        set_pkt(1, 0, 1, 1, 0, 2'b01, 32'hC, 32'h0); tick();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_tmask", out_tmask, 4'b0111);
        chk("t1_data", out_data, pack4(32'hA, 32'hB, 32'hC, 32'h0));
        chk("t1_wid", out_wid, 2'd1);
        chk("t1_err", err, 0);
        tick();
        chk("t1_count", commit_count, 1);
        chk("t1_drained", out_valid, 0);

        // backpressure
        out_ready = 1'b0;
        set_pkt(0, 1, 0, 2, 1, 2'b11, 32'hD, 32'hE); tick();
        set_pkt(1, 0, 1, 2, 1, 2'b11, 32'hF, 32'h6); tick();
        set_pkt(0, 1, 0, 3, 0, 2'b11, 32'h11, 32'h12);
        chk("t2_valid", out_valid, 1);
        chk("t2_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_data", out_data, pack4(32'hD, 32'hE, 32'hF, 32'h6));
            chk("t2_hold_wid", out_wid, 2'd2);
            chk("t2_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("t2_ready_up", in_ready, 1);
        tick();
        chk("t2_count", commit_count, 2);
        chk("t2_after_hs", out_valid, 0);
        set_pkt(1, 0, 1, 3, 0, 2'b10, 32'h0, 32'h13); tick();
        in_valid = 1'b0;
        chk("t2_next_valid", out_valid, 1);
        chk("t2_next_tmask", out_tmask, 4'b1011);
        chk("t2_next_data", out_data, pack4(32'h11, 32'h12, 32'h0, 32'h13));
        chk("t2_next_wid", out_wid, 2'd3);
        tick();
        chk("t2_count2", commit_count, 3);

        // streaming
        for (int w = 0; w < 8; w++) begin
            base = 32'h100 + 32'(w) * 4;
            set_pkt(0, 1, 0, 2'(w), 0, 2'b11, base, base + 1); tick();
            chk("t3_gap_valid", out_valid, 0);
            chk("t3_count", commit_count, 32'd3 + 32'(w));
            set_pkt(1, 0, 1, 2'(w), 0, 2'b11, base + 2, base + 3); tick();
            chk("t3_valid", out_valid, 1);
            chk("t3_data", out_data, pack4(base, base + 1, base + 2, base + 3));
            chk("t3_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("t3_final_count", commit_count, 11);
        chk("t3_final_valid", out_valid, 0);
        chk("t3_err", err, 0);

        // sequencing errors
        pulse_reset();
        chk("t4_rst_count", commit_count, 0);
        set_pkt(1, 0, 1, 1, 0, 2'b11, 32'h21, 32'h22); tick();
        in_valid = 1'b0;
        chk("t4_err_idle", err, 1);
        chk("t4_drop_valid", out_valid, 0);
        tick();
        chk("t4_drop_valid2", out_valid, 0);
        set_pkt(0, 1, 0, 1, 0, 2'b11, 32'h31, 32'h32); tick();
        set_pkt(0, 1, 0, 1, 1, 2'b11, 32'h41, 32'h42); tick();
        set_pkt(1, 0, 1, 1, 1, 2'b11, 32'h43, 32'h44); tick();
        in_valid = 1'b0;
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, pack4(32'h41, 32'h42, 32'h43, 32'h44));
        chk("t4_uuid", out_uuid, 1);
        tick();
        chk("t4_count", commit_count, 1);
        tick();
        chk("t4_idle_valid", out_valid, 0);
        chk("t4_count_hold", commit_count, 1);

        // wid mismatch
        pulse_reset();
        chk("t5_rst_err", err, 0);
        set_pkt(0, 1, 0, 1, 0, 2'b11, 32'h51, 32'h52); tick();
        set_pkt(1, 0, 1, 2, 0, 2'b11, 32'hEE, 32'hEF); tick();
        chk("t5_err", err, 1);
        chk("t5_drop_valid", out_valid, 0);
        set_pkt(1, 0, 1, 1, 0, 2'b01, 32'h53, 32'h0); tick();
        in_valid = 1'b0;
        chk("t5_valid", out_valid, 1);
        chk("t5_wid", out_wid, 2'd1);
        chk("t5_tmask", out_tmask, 4'b0111);
        chk("t5_data", out_data, pack4(32'h51, 32'h52, 32'h53, 32'h0));
        tick();
        chk("t5_count", commit_count, 1);

        // reset mid-ACCUM and mid-FULL
        set_pkt(0, 1, 0, 1, 0, 2'b11, 32'h61, 32'h62); tick();
        pulse_reset();
        chk("t6a_valid", out_valid, 0);
        chk("t6a_count", commit_count, 0);
        chk("t6a_err", err, 0);
        set_pkt(1, 0, 1, 1, 0, 2'b11, 32'h63, 32'h64); tick();
        in_valid = 1'b0;
        chk("t6a_no_stale", out_valid, 0);
        tick();
        chk("t6a_no_stale2", out_valid, 0);
        chk("t6a_tmask", out_tmask, 0);
        out_ready = 1'b0;
        set_pkt(0, 1, 0, 2, 0, 2'b11, 32'h71, 32'h72); tick();
        set_pkt(1, 0, 1, 2, 0, 2'b11, 32'h73, 32'h74); tick();
        in_valid = 1'b0;
        chk("t6b_full", out_valid, 1);
        pulse_reset();
        out_ready = 1'b1;
        chk("t6b_valid", out_valid, 0);
        chk("t6b_count", commit_count, 0);
        chk("t6b_err", err, 0);
        chk("t6b_tmask", out_tmask, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6b_no_stale", out_valid, 0);
        end
        chk("t6b_final_count", commit_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vx_alu_commit_assembler.md
Name: vx_alu_commit_assembler

Overview:
- Sits directly downstream of the ALU unit's per-block response arbiter, in partial-bandwidth configurations (NUM_LANES < NUM_THREADS).
- Consumes a stream of partial-warp commit packets, each tagged with pid/sop/eop.
- Reassembles them into one full-warp (NUM_THREADS-wide) commit toward writeback.
- Holds one assembled warp, detects sequencing violations and counts committed warps.

Parameters:
- NUM_THREADS, 4, threads per warp (power of 2).
- NUM_LANES, 2, lanes per input packet (power of 2, ≤ NUM_THREADS).
- XLEN, 32, data width per lane.
- NW_WIDTH, 2, warp-id width.
- UUID_WIDTH, 1, instruction uuid width.
- PC_BITS, 30, PC width.
- NR_BITS, 6, register-index width.
- PID_WIDTH, max(1, log2(NUM_THREADS/NUM_LANES)), packet-index width (derived).

Ports:
- clk in 1: single clock.
- reset in 1: synchronous, active-low (0 = reset), sampled on rising clk.
- in_valid in 1: input packet valid.
- in_ready out 1: input packet accepted when in_valid && in_ready.
- in_uuid in UUID_WIDTH, in_wid in NW_WIDTH, in_pc in PC_BITS, in_rd in NR_BITS, in_wb in 1: instruction header.
- in_tmask in NUM_LANES: lane mask.
- in_data in NUM_LANES*XLEN: lane results.
- in_pid in PID_WIDTH: packet index within the warp.
- in_sop in 1: first packet of the warp.
- in_eop in 1: last packet of the warp.
- out_valid out 1, out_ready in 1: output handshake.
- out_uuid, out_wid, out_pc, out_rd, out_wb out (header widths): held header.
- out_tmask out NUM_THREADS, out_data out NUM_THREADS*XLEN: assembled warp.
- err out 1: sticky sequencing-error flag.
- commit_count out 32: number of warps handed off.

Behaviour:
- State: IDLE (nothing held), ACCUM (sop seen, awaiting eop), FULL (warp held, out_valid=1).
- Reset (reset==0 at posedge): state=IDLE; out_valid=0; err=0; commit_count=0; accumulated tmask/data=0; header regs=0. Reset mid-ACCUM or mid-FULL discards the partial or held warp without output.
- in_ready = (state!=FULL) || out_ready, combinational; there is no combinational path from in_valid to out_valid.
- Lane placement: accepted packet writes tmask/data to lanes [pid*NUM_LANES +: NUM_LANES]. When NUM_LANES==NUM_THREADS, pid is ignored and every packet must carry sop=eop=1.
- IDLE + accept with sop=1: clear all tmask/data, latch header, place lanes. Next state is FULL if eop=1, else ACCUM.
- IDLE + accept with sop=0: drop the packet, set err.
- ACCUM + accept with sop=0 and matching wid/uuid: place lanes (overwriting); next state is FULL if eop=1.
- ACCUM + accept with sop=0 and wid or uuid mismatch: drop the packet, set err, stay ACCUM.
- ACCUM + accept with sop=1: discard the partial warp, set err, restart as in IDLE+sop.
- Duplicate pid within one warp: overwrite the lanes, set err.
- FULL + out_ready=1 + input accepted in the same cycle: output handshake completes and the new packet is processed as IDLE (back-to-back, no bubble).
- FULL + out_ready=0: in_ready=0; outputs held stable until the handshake.
- Latency: eop accepted at cycle N → out_valid=1 at N+1. Throughput: one warp per NUM_THREADS/NUM_LANES cycles with continuous valid/ready.
- commit_count increments by 1 on each out_valid&&out_ready and wraps modulo 2^32.
- Lanes never written in a warp present tmask=0 and data=0.
- err is sticky; only reset clears it.

Test Plan (NUM_THREADS=4, NUM_LANES=2, XLEN=32):
- Two-packet warp: pid0 {sop, tmask=11, data=A,B}, then pid1 {eop, tmask=01, data=C,x}, wid=1, out_ready=1 → one cycle after eop: out_valid, out_tmask=0111, out_data lanes0..2=A,B,C, lane3=0, commit_count=1, err=0.
- Backpressure: hold out_ready=0 after a completed warp, present the next sop → in_ready=0, outputs stable for 5 cycles. Then raise out_ready → handshake and sop acceptance in the same cycle, next warp emitted 2 cycles later.
- Streaming: 8 warps back-to-back with out_ready=1 → 8 outputs, one every 2 cycles, commit_count=8, no bubbles.
- Errors: sop=0 packet in IDLE → dropped, err=1. Then sop mid-ACCUM → first warp discarded, only the second warp emitted, commit_count=1.
- Wid mismatch: mid-warp packet with wid=2 while wid=1 is held → dropped, err=1, completion with a wid=1 eop still emits.
- Reset: apply reset=0 while in ACCUM and again while in FULL → out_valid=0, commit_count=0, err=0 next cycle, and no stale warp is emitted afterwards.
